// File: rtl/mdu_issue_pkg.sv
// Shared types for the MDU issue sequencer: micro-op encodings, result classes,
// request/response bundles and the single cache line layout.
package mdu_issue_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned TAG_W_MAX = 16;

  typedef logic [XLEN-1:0]      word_t;
  typedef logic [2*XLEN-1:0]    dword_t;
  typedef logic [TAG_W_MAX-1:0] tag_t;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_MUL    = 4'd1,
    OP_MULH   = 4'd2,
    OP_MULHSU = 4'd3,
    OP_MULHU  = 4'd4,
    OP_DIV    = 4'd5,
    OP_DIVU   = 4'd6,
    OP_REM    = 4'd7,
    OP_REMU   = 4'd8,
    OP_CLMUL  = 4'd9,
    OP_CLMULH = 4'd10,
    OP_CLMULR = 4'd11
  } op_t;

  // Ops sharing a class produce both halves of one MDU run.
  typedef enum logic [2:0] {
    CLS_DIVS  = 3'd0,
    CLS_DIVU  = 3'd1,
    CLS_MULSS = 3'd2,
    CLS_MULSU = 3'd3,
    CLS_MULUU = 3'd4,
    CLS_CLMUL = 3'd5
  } mdu_class_t;

  typedef struct packed {
    mdu_class_t cls;
    logic       cacheable;
    logic       hi_half;
  } mdu_class_info_t;

  typedef struct packed {
    op_t   op;
    word_t rs1;
    word_t rs2;
    tag_t  tag;
  } mdu_req_t;

  typedef struct packed {
    word_t data;
    tag_t  tag;
  } mdu_resp_t;

  typedef struct packed {
    logic       valid;
    mdu_class_t cls;
    word_t      rs1;
    word_t      rs2;
    word_t      hi_word;
    word_t      lo_word;
  } mdu_cache_line_t;

endpackage

// File: rtl/mdu_issue_if.sv
// Issue-side request and writeback-side response handshakes of the MDU sequencer.
interface mdu_issue_if #(
  parameter int unsigned TAG_W = 5
);
  import mdu_issue_pkg::*;

  logic             req_valid;
  logic             req_ready;
  op_t              req_op;
  word_t            req_rs1;
  word_t            req_rs2;
  logic [TAG_W-1:0] req_tag;

  logic             resp_valid;
  logic             resp_ready;
  word_t            resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );

endinterface

// File: rtl/mdu_result_cache.sv
// Single-entry cache of the last full MDU result, keyed by class and operands.
module mdu_result_cache
  import mdu_issue_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  mdu_class_t lookup_cls,
  input  word_t      lookup_rs1,
  input  word_t      lookup_rs2,
  output logic       lookup_hit,
  output dword_t     lookup_line,
  input  logic       fill_en,
  input  mdu_class_t fill_cls,
  input  word_t      fill_rs1,
  input  word_t      fill_rs2,
  input  dword_t     fill_line
);

  mdu_cache_line_t entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      entry <= '0;
    end else if (fill_en) begin
      entry.valid   <= 1'b1;
      entry.cls     <= fill_cls;
      entry.rs1     <= fill_rs1;
      entry.rs2     <= fill_rs2;
      entry.hi_word <= fill_line[2*XLEN-1:XLEN];
      entry.lo_word <= fill_line[XLEN-1:0];
    end
  end

  assign lookup_hit  = entry.valid && (entry.cls == lookup_cls) &&
                       (entry.rs1 == lookup_rs1) && (entry.rs2 == lookup_rs2);
  assign lookup_line = {entry.hi_word, entry.lo_word};

endmodule

// File: rtl/mdu_issue.sv
// Execute-stage sequencer for the multi-cycle MDU: accepts one micro-op, drives the
// MDU until done, returns the selected word, and short-circuits paired ops via a cache.
module mdu_issue
  import mdu_issue_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  mdu_issue_if.slave io,
  output logic  mdu_flush,
  output op_t   mdu_op,
  output word_t mdu_rs1,
  output word_t mdu_rs2,
  input  dword_t mdu_mul_ss,
  input  dword_t mdu_mul_su,
  input  dword_t mdu_mul_uu,
  input  dword_t mdu_clmul,
  input  dword_t mdu_clmulr,
  input  word_t mdu_div_s,
  input  word_t mdu_div_u,
  input  word_t mdu_rem_s,
  input  word_t mdu_rem_u,
  input  logic  mdu_busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  function automatic mdu_class_info_t op_to_class(op_t op);
    mdu_class_info_t ci;
    ci = '{cls: CLS_MULSS, cacheable: 1'b1, hi_half: 1'b0};
    case (op)
      OP_MUL:    ci.cls = CLS_MULSS;
      OP_MULH:   begin ci.cls = CLS_MULSS; ci.hi_half = 1'b1; end
      OP_MULHSU: begin ci.cls = CLS_MULSU; ci.hi_half = 1'b1; end
      OP_MULHU:  begin ci.cls = CLS_MULUU; ci.hi_half = 1'b1; end
      OP_DIV:    ci.cls = CLS_DIVS;
      OP_REM:    begin ci.cls = CLS_DIVS; ci.hi_half = 1'b1; end
      OP_DIVU:   ci.cls = CLS_DIVU;
      OP_REMU:   begin ci.cls = CLS_DIVU; ci.hi_half = 1'b1; end
      OP_CLMUL:  ci.cls = CLS_CLMUL;
      OP_CLMULH: begin ci.cls = CLS_CLMUL; ci.hi_half = 1'b1; end
      default:   ci.cacheable = 1'b0;
    endcase
    return ci;
  endfunction

  state_t          state;
  logic            ready_q;
  logic            resp_valid_q;
  mdu_req_t        req_q;
  mdu_resp_t       resp_q;

  mdu_class_info_t req_ci;
  mdu_class_info_t cur_ci;
  logic            cache_hit;
  dword_t          cache_line;
  word_t           hit_word;
  logic            hit_now;
  word_t           mdu_result;
  dword_t          fill_line;
  logic            fill_en;
  logic            unused_bits;

  assign req_ci   = op_to_class(io.req_op);
  assign cur_ci   = op_to_class(req_q.op);
  assign hit_now  = cache_hit && req_ci.cacheable;
  assign hit_word = req_ci.hi_half ? cache_line[2*XLEN-1:XLEN] : cache_line[XLEN-1:0];
  assign fill_en  = (state == S_WAIT) && !mdu_busy && !flush && cur_ci.cacheable;

  always_comb begin
    mdu_result = '0;
    case (req_q.op)
      OP_MUL:    mdu_result = mdu_mul_ss[XLEN-1:0];
      OP_MULH:   mdu_result = mdu_mul_ss[2*XLEN-1:XLEN];
      OP_MULHSU: mdu_result = mdu_mul_su[2*XLEN-1:XLEN];
      OP_MULHU:  mdu_result = mdu_mul_uu[2*XLEN-1:XLEN];
      OP_DIV:    mdu_result = mdu_div_s;
      OP_DIVU:   mdu_result = mdu_div_u;
      OP_REM:    mdu_result = mdu_rem_s;
      OP_REMU:   mdu_result = mdu_rem_u;
      OP_CLMUL:  mdu_result = mdu_clmul[XLEN-1:0];
      OP_CLMULH: mdu_result = mdu_clmul[2*XLEN-1:XLEN];
      OP_CLMULR: mdu_result = mdu_clmulr[XLEN-1:0];
      default:   mdu_result = '0;
    endcase
  end

  // Divides keep the quotient low and the remainder high, matching the hi_half of REM/REMU.
  always_comb begin
    fill_line = '0;
    case (cur_ci.cls)
      CLS_DIVS:  fill_line = {mdu_rem_s, mdu_div_s};
      CLS_DIVU:  fill_line = {mdu_rem_u, mdu_div_u};
      CLS_MULSS: fill_line = mdu_mul_ss;
      CLS_MULSU: fill_line = mdu_mul_su;
      CLS_MULUU: fill_line = mdu_mul_uu;
      CLS_CLMUL: fill_line = mdu_clmul;
      default:   fill_line = '0;
    endcase
  end

  mdu_result_cache u_cache (
    .clk         (clk),
    .rst         (rst),
    .lookup_cls  (req_ci.cls),
    .lookup_rs1  (io.req_rs1),
    .lookup_rs2  (io.req_rs2),
    .lookup_hit  (cache_hit),
    .lookup_line (cache_line),
    .fill_en     (fill_en),
    .fill_cls    (cur_ci.cls),
    .fill_rs1    (req_q.rs1),
    .fill_rs2    (req_q.rs2),
    .fill_line   (fill_line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      req_q        <= '0;
      resp_q       <= '0;
      mdu_op       <= OP_NOP;
      mdu_rs1      <= '0;
      mdu_rs2      <= '0;
    end else if (flush) begin
      state        <= S_IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      mdu_op       <= OP_NOP;
      mdu_rs1      <= '0;
      mdu_rs2      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.req_valid) begin
            req_q   <= '{op: io.req_op, rs1: io.req_rs1, rs2: io.req_rs2,
                         tag: tag_t'(io.req_tag)};
            ready_q <= 1'b0;
            if (hit_now) begin
              resp_q       <= '{data: hit_word, tag: tag_t'(io.req_tag)};
              resp_valid_q <= 1'b1;
              state        <= S_RESP;
            end else begin
              mdu_op  <= io.req_op;
              mdu_rs1 <= io.req_rs1;
              mdu_rs2 <= io.req_rs2;
              state   <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: state <= S_WAIT;
        S_WAIT: begin
          if (!mdu_busy) begin
            resp_q       <= '{data: mdu_result, tag: req_q.tag};
            resp_valid_q <= 1'b1;
            mdu_op       <= OP_NOP;
            mdu_rs1      <= '0;
            mdu_rs2      <= '0;
            state        <= S_RESP;
          end
        end
        S_RESP: begin
          if (io.resp_ready) begin
            resp_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io.req_ready  = ready_q && !flush;
  assign io.resp_valid = resp_valid_q;
  assign io.resp_data  = resp_q.data;
  assign io.resp_tag   = resp_q.tag[TAG_W-1:0];
  assign mdu_flush     = flush;

  // Upper CLMULR half is never selected; tag storage is sized for the widest TAG_W.
  assign unused_bits = ^{mdu_clmulr[2*XLEN-1:XLEN], resp_q.tag};

endmodule

// File: tb/tb_mdu_issue.sv
// Self-checking bench for mdu_issue: behavioural MDU with programmable busy length,
// reference arithmetic plus a one-entry cache model predicting hit/miss latency.
`timescale 1ns/1ps
module tb_mdu_issue;
  import mdu_issue_pkg::*;

  localparam int unsigned TAG_W = 5;

  logic   clk = 1'b0;
  logic   rst;
  logic   flush;
  logic   mdu_flush;
  op_t    mdu_op;
  word_t  mdu_rs1, mdu_rs2;
  dword_t mdu_mul_ss, mdu_mul_su, mdu_mul_uu, mdu_clmul, mdu_clmulr;
  word_t  mdu_div_s, mdu_div_u, mdu_rem_s, mdu_rem_u;
  logic   mdu_busy;

  int checks   = 0;
  int failures = 0;

  int unsigned prog_busy = 0;
  int unsigned busy_left = 0;
  logic        prev_active = 1'b0;

  bit    cm_valid = 1'b0;
  int    cm_cls   = -1;
  word_t cm_a, cm_b;

  always #5 clk = ~clk;

  mdu_issue_if #(.TAG_W(TAG_W)) io ();

  mdu_issue #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .io(io),
    .mdu_flush(mdu_flush), .mdu_op(mdu_op), .mdu_rs1(mdu_rs1), .mdu_rs2(mdu_rs2),
    .mdu_mul_ss(mdu_mul_ss), .mdu_mul_su(mdu_mul_su), .mdu_mul_uu(mdu_mul_uu),
    .mdu_clmul(mdu_clmul), .mdu_clmulr(mdu_clmulr),
    .mdu_div_s(mdu_div_s), .mdu_div_u(mdu_div_u), .mdu_rem_s(mdu_rem_s), .mdu_rem_u(mdu_rem_u),
    .mdu_busy(mdu_busy)
  );

  function automatic dword_t f_mul_ss(word_t a, word_t b);
    return dword_t'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
  endfunction
  function automatic dword_t f_mul_su(word_t a, word_t b);
    return dword_t'($signed({{32{a[31]}}, a}) * $signed({32'h0, b}));
  endfunction
  function automatic dword_t f_mul_uu(word_t a, word_t b);
    return {32'h0, a} * {32'h0, b};
  endfunction
  function automatic word_t f_div_s(word_t a, word_t b);
    if (b == 0) return 32'hFFFFFFFF;
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
    return word_t'($signed(a) / $signed(b));
  endfunction
  function automatic word_t f_rem_s(word_t a, word_t b);
    if (b == 0) return a;
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
    return word_t'($signed(a) % $signed(b));
  endfunction
  function automatic word_t f_div_u(word_t a, word_t b);
    return (b == 0) ? 32'hFFFFFFFF : a / b;
  endfunction
  function automatic word_t f_rem_u(word_t a, word_t b);
    return (b == 0) ? a : a % b;
  endfunction
  function automatic dword_t f_clmul(word_t a, word_t b);
    dword_t r = '0;
    for (int i = 0; i < 32; i++) if (b[i]) r = r ^ (dword_t'(a) << i);
    return r;
  endfunction
  function automatic word_t f_clmulr(word_t a, word_t b);
    word_t r = '0;
    for (int i = 0; i < 32; i++) if (b[i]) r = r ^ (a >> (31 - i));
    return r;
  endfunction

  function automatic word_t ref_result(op_t op, word_t a, word_t b);
    dword_t p;
    case (op)
      OP_MUL:    begin p = f_mul_ss(a, b); return p[31:0];  end
      OP_MULH:   begin p = f_mul_ss(a, b); return p[63:32]; end
      OP_MULHSU: begin p = f_mul_su(a, b); return p[63:32]; end
      OP_MULHU:  begin p = f_mul_uu(a, b); return p[63:32]; end
      OP_DIV:    return f_div_s(a, b);
      OP_DIVU:   return f_div_u(a, b);
      OP_REM:    return f_rem_s(a, b);
      OP_REMU:   return f_rem_u(a, b);
      OP_CLMUL:  begin p = f_clmul(a, b); return p[31:0];  end
      OP_CLMULH: begin p = f_clmul(a, b); return p[63:32]; end
      OP_CLMULR: return f_clmulr(a, b);
      default:   return 32'h0;
    endcase
  endfunction

  function automatic int ref_class(op_t op);
    case (op)
      OP_MUL, OP_MULH:     return 0;
      OP_MULHSU:           return 1;
      OP_MULHU:            return 2;
      OP_DIV, OP_REM:      return 3;
      OP_DIVU, OP_REMU:    return 4;
      OP_CLMUL, OP_CLMULH: return 5;
      default:             return -1;
    endcase
  endfunction

  // Behavioural MDU: busy for prog_busy WAIT cycles, garbage outputs while not driven.
  always @(negedge clk) begin
    if (mdu_op != OP_NOP) begin
      if (!prev_active)        busy_left <= prog_busy + 1;
      else if (busy_left > 0)  busy_left <= busy_left - 1;
      mdu_mul_ss <= f_mul_ss(mdu_rs1, mdu_rs2);
      mdu_mul_su <= f_mul_su(mdu_rs1, mdu_rs2);
      mdu_mul_uu <= f_mul_uu(mdu_rs1, mdu_rs2);
      mdu_clmul  <= f_clmul(mdu_rs1, mdu_rs2);
      mdu_clmulr <= {$urandom, f_clmulr(mdu_rs1, mdu_rs2)};
      mdu_div_s  <= f_div_s(mdu_rs1, mdu_rs2);
      mdu_div_u  <= f_div_u(mdu_rs1, mdu_rs2);
      mdu_rem_s  <= f_rem_s(mdu_rs1, mdu_rs2);
      mdu_rem_u  <= f_rem_u(mdu_rs1, mdu_rs2);
    end else begin
      busy_left  <= 0;
      mdu_mul_ss <= {$urandom, $urandom};
      mdu_mul_su <= {$urandom, $urandom};
      mdu_mul_uu <= {$urandom, $urandom};
      mdu_clmul  <= {$urandom, $urandom};
      mdu_clmulr <= {$urandom, $urandom};
      mdu_div_s  <= $urandom;
      mdu_div_u  <= $urandom;
      mdu_rem_s  <= $urandom;
      mdu_rem_u  <= $urandom;
    end
    prev_active <= (mdu_op != OP_NOP);
  end
  assign mdu_busy = (busy_left != 0);

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Presents one request in IDLE; returns #1 after the accepting edge.
  task automatic start_req(input op_t op, input word_t a, input word_t b,
                           input logic [TAG_W-1:0] tag, input int unsigned nbusy, input bit rdy);
    prog_busy     = nbusy;
    io.req_valid  = 1'b1;
    io.req_op     = op;
    io.req_rs1    = a;
    io.req_rs2    = b;
    io.req_tag    = tag;
    io.resp_ready = rdy;
    @(negedge clk);
    check("req_ready_idle", io.req_ready, 1);
    @(posedge clk); #1;
    io.req_valid = 1'b0;
  endtask

  task automatic do_op(input op_t op, input word_t a, input word_t b,
                       input int unsigned nbusy, input int unsigned stall, output word_t got);
    logic [TAG_W-1:0] tag;
    bit          hit, hold_ok, stable_ok;
    int          cls;
    word_t       exp;
    int unsigned lat, exp_lat;
    tag     = TAG_W'($urandom);
    cls     = ref_class(op);
    hit     = cm_valid && cls >= 0 && cls == cm_cls && a == cm_a && b == cm_b;
    exp     = ref_result(op, a, b);
    exp_lat = hit ? 1 : 3 + nbusy;
    start_req(op, a, b, tag, nbusy, stall == 0);
    lat = 0;
    hold_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!io.resp_valid) begin
        if (io.req_ready) hold_ok = 1'b0;
        if (hit || mdu_op != op || mdu_rs1 != a || mdu_rs2 != b) hold_ok = 1'b0;
      end
    end while (!io.resp_valid && lat < 40);
    check("latency", lat, exp_lat);
    check("mdu_hold", hold_ok, 1);
    check("resp_data", io.resp_data, exp);
    check("resp_tag", io.resp_tag, tag);
    check("mdu_nop_in_resp", mdu_op, OP_NOP);
    got = io.resp_data;
    stable_ok = 1'b1;
    for (int i = 1; i < int'(stall); i++) begin
      @(negedge clk);
      if (!io.resp_valid || io.resp_data != exp || io.resp_tag != tag || io.req_ready)
        stable_ok = 1'b0;
    end
    if (stall > 0) begin
      check("resp_stall_stable", stable_ok, 1);
      @(posedge clk); #1;
      io.resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("resp_drop", io.resp_valid, 0);
    if (!hit && cls >= 0) begin
      cm_valid = 1'b1; cm_cls = cls; cm_a = a; cm_b = b;
    end
  endtask

  initial begin : stim
    word_t got;
    word_t pool [6];
    word_t la, lb, a, b;
    bit    quiet_ok;
    pool = '{32'h0, 32'h1, 32'h7, 32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFFF};
    rst = 1'b1; flush = 1'b0;
    io.req_valid = 1'b0; io.req_op = OP_NOP; io.req_rs1 = '0; io.req_rs2 = '0;
    io.req_tag = '0; io.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", io.req_ready, 1);
    check("rst_resp_valid", io.resp_valid, 0);
    check("rst_resp_data", io.resp_data, 0);
    check("rst_resp_tag", io.resp_tag, 0);
    check("rst_mdu_op", mdu_op, OP_NOP);
    check("rst_mdu_rs", {mdu_rs1, mdu_rs2}, 0);
    @(posedge clk); #1;

    do_op(OP_DIV, 32'hFFFFFFF9, 32'h2, 5, 0, got);   check("div_m7_2", got, 32'hFFFFFFFD);
    do_op(OP_REM, 32'hFFFFFFF9, 32'h2, 5, 0, got);   check("rem_m7_2_hit", got, 32'hFFFFFFFF);
    do_op(OP_MUL, 32'h7, 32'hFFFFFFFD, 0, 0, got);   check("mul_7_m3", got, 32'hFFFFFFEB);
    do_op(OP_MULH, 32'h7, 32'hFFFFFFFD, 0, 0, got);  check("mulh_hit", got, 32'hFFFFFFFF);
    do_op(OP_MULHU, 32'h7, 32'hFFFFFFFD, 2, 0, got); check("mulhu_miss", got, 32'h6);
    do_op(OP_DIV, 32'h5, 32'h0, 1, 0, got);          check("div_by_zero", got, 32'hFFFFFFFF);
    do_op(OP_DIVU, 32'h5, 32'h0, 1, 0, got);         check("divu_by_zero", got, 32'hFFFFFFFF);

    // Flush in the third WAIT cycle of DIV 100/7.
    start_req(OP_DIV, 32'd100, 32'd7, 5'h0A, 10, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    check("mdu_flush_fwd", mdu_flush, 1);
    check("req_ready_flush", io.req_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    quiet_ok = 1'b1;
    @(negedge clk);
    check("flush_idle_ready", io.req_ready, 1);
    check("flush_mdu_op", mdu_op, OP_NOP);
    repeat (8) begin
      if (io.resp_valid) quiet_ok = 1'b0;
      @(negedge clk);
    end
    check("flush_no_resp", quiet_ok, 1);
    @(posedge clk); #1;
    do_op(OP_REM, 32'd100, 32'd7, 1, 0, got); check("rem_after_flush", got, 32'd2);

    // Request coincident with flush must not be accepted.
    io.req_valid = 1'b1; io.req_op = OP_DIV; io.req_rs1 = 32'd1; io.req_rs2 = 32'd1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_gates_ready", io.req_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; io.req_valid = 1'b0;
    @(negedge clk);
    check("flush_req_dropped", mdu_op, OP_NOP);
    check("flush_req_no_resp", io.resp_valid, 0);
    @(posedge clk); #1;

    do_op(OP_CLMUL, 32'h5, 32'h3, 1, 4, got); check("clmul_stall", got, 32'hF);

    // Reset in the middle of WAIT drops both the op and the cache.
    do_op(OP_DIV, 32'd9, 32'd4, 0, 0, got); check("div_9_4", got, 32'd2);
    start_req(OP_MULHU, 32'd3, 32'd3, 5'h03, 10, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstwait_req_ready", io.req_ready, 1);
    check("rstwait_resp_valid", io.resp_valid, 0);
    check("rstwait_mdu_op", mdu_op, OP_NOP);
    cm_valid = 1'b0;
    @(posedge clk); #1;
    do_op(OP_REM, 32'd9, 32'd4, 0, 0, got); check("rem_after_rst_miss", got, 32'd1);

    la = 32'd0; lb = 32'd1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        a = la; b = lb;
      end else begin
        a = ($urandom_range(0, 3) == 0) ? word_t'($urandom) : pool[$urandom_range(0, 5)];
        b = ($urandom_range(0, 3) == 0) ? word_t'($urandom) : pool[$urandom_range(0, 5)];
      end
      do_op(op_t'($urandom_range(1, 11)), a, b, $urandom_range(0, 3), $urandom_range(0, 2), got);
      la = a; lb = b;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
